// File: rtl/hld_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : hld_ctrl_gen
// Brief    : Periodic multi-channel hold-control generator with shadowed
//            configuration. Define HLD_CTRL_GEN_NOVL_EN for non-overlap masking.
// Revision : 1.0
// ============================================================================
module hld_ctrl_gen #(
    parameter int NCH   = 2,
    parameter int DIV_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [DIV_W-1:0]   div_m,
    input  logic [DIV_W-1:0]   hld_len,
    input  logic [NCH*DIV_W-1:0] ch_ofs,
    input  logic               upd_req,
    output logic               upd_ack,
    output logic [NCH-1:0]     ctrl_hld,
    output logic               frame
);

    localparam int CW = DIV_W + 1;

    logic             r_mode_s;
    logic [DIV_W-1:0] r_div_m_s;
    logic [DIV_W-1:0] r_hld_len_s;
    logic [DIV_W-1:0] r_ofs_s [NCH];
    logic [CW-1:0]    r_cnt;
    logic [NCH-1:0]   r_ctrl;
    logic             r_frame;
    logic             r_ack;

    logic [CW-1:0]    w_per;
    logic [CW-1:0]    w_hld_eff;
    logic             w_last;
    logic             w_load;
    logic [CW-1:0]    w_ofs_eff [NCH];
    logic [CW-1:0]    w_rel [NCH];
    logic [NCH-1:0]   w_hit;
    logic [NCH-1:0]   w_mask;

    // Period is one wider than the divide field so div_m_s=all-ones gives 2^DIV_W.
    always_comb begin
        w_per = CW'(2);
        if (!r_mode_s && (r_div_m_s != '0)) begin
            w_per = {1'b0, r_div_m_s} + CW'(1);
        end
    end

    assign w_hld_eff = r_mode_s ? CW'(|r_hld_len_s) : {1'b0, r_hld_len_s};
    assign w_last    = (r_cnt >= (w_per - CW'(1)));
    // The ack cycle is excluded so a held request reloads at the next eligible point.
    assign w_load    = upd_req && !r_ack && (!en || w_last);

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign w_ofs_eff[k] = r_mode_s ? CW'(|r_ofs_s[k]) : {1'b0, r_ofs_s[k]};
            assign w_rel[k]     = (r_cnt >= w_ofs_eff[k]) ? (r_cnt - w_ofs_eff[k])
                                                          : (r_cnt + w_per - w_ofs_eff[k]);
            assign w_hit[k]     = (w_ofs_eff[k] < w_per) && (w_rel[k] < w_hld_eff);
        end
    endgenerate

`ifdef HLD_CTRL_GEN_NOVL_EN
    logic w_any;
    always_comb begin
        w_mask = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_mask[k] = w_hit[k] && !w_any;
            w_any     = w_any || w_hit[k];
        end
    end
`else
    assign w_mask = w_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s    <= 1'b0;
            r_div_m_s   <= DIV_W'(1);
            r_hld_len_s <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_ofs_s[k] <= '0;
            end
            r_cnt   <= '0;
            r_ctrl  <= '0;
            r_frame <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_load;
            if (w_load) begin
                r_mode_s    <= mode;
                r_div_m_s   <= div_m;
                r_hld_len_s <= hld_len;
                for (int k = 0; k < NCH; k++) begin
                    r_ofs_s[k] <= ch_ofs[k*DIV_W +: DIV_W];
                end
            end
            if (!en || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_ctrl  <= en ? w_mask : '0;
            r_frame <= en && (r_cnt == '0);
        end
    end

    assign upd_ack  = r_ack;
    assign ctrl_hld = r_ctrl;
    assign frame    = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_hld_ctrl_gen.sv
`default_nettype none
// Scoreboard bench for hld_ctrl_gen: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_hld_ctrl_gen;

    localparam int NCH   = 2;
    localparam int DIV_W = 4;
`ifdef HLD_CTRL_GEN_NOVL_EN
    localparam bit NOVL = 1'b1;
`else
    localparam bit NOVL = 1'b0;
`endif
    localparam logic [15:0] C_P4_CH1 = NOVL ? 16'b1000 : 16'b1001;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 mode;
    logic [DIV_W-1:0]     div_m;
    logic [DIV_W-1:0]     hld_len;
    logic [NCH*DIV_W-1:0] ch_ofs;
    logic                 upd_req;
    logic                 upd_ack;
    logic [NCH-1:0]       ctrl_hld;
    logic                 frame;

    hld_ctrl_gen #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .div_m    (div_m),
        .hld_len  (hld_len),
        .ch_ofs   (ch_ofs),
        .upd_req  (upd_req),
        .upd_ack  (upd_ack),
        .ctrl_hld (ctrl_hld),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [1:0] ctrl;
        logic       frm;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].stamp <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.stamp != cyc || {ctrl_hld, frame, upd_ack} !== {e.ctrl, e.frm, e.ack}) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d ctrl/frame/ack got %b/%b/%b want %b/%b/%b",
                             cyc, ctrl_hld, frame, upd_ack, e.ctrl, e.frm, e.ack);
                end
            end
        end
    end

    task automatic step(input logic [1:0] c, input logic f, input logic a);
        q.push_back('{cyc + 1, c, f, a});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat(input int ph, input logic [15:0] p0, input logic [15:0] p1);
        return {p1[ph], p0[ph]};
    endfunction

    // Starts (or continues) from cnt=0 with en high.
    task automatic run(input int per, input logic [15:0] p0, input logic [15:0] p1, input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            step(pat(i % per, p0, p1), (i % per) == 0, 1'b0);
        end
    endtask

    task automatic stop();
        en = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic m, input logic [3:0] d, input logic [3:0] h,
                       input logic [3:0] o1, input logic [3:0] o0);
        en      = 1'b0;
        mode    = m;
        div_m   = d;
        hld_len = h;
        ch_ofs  = {o1, o0};
        upd_req = 1'b1;
        step(2'b00, 1'b0, 1'b1);
        upd_req = 1'b0;
        step(2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; div_m = '0; hld_len = '0; ch_ofs = '0; upd_req = 1'b0;
        @(posedge clk);
        #1;
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset shadows: P=2, hold length 0.
        run(2, 16'h0, 16'h0, 4);
        stop();

        // Basic P=6 operation.
        cfg(1'b0, 4'd5, 4'd2, 4'd3, 4'd0);
        run(6, 16'b000011, 16'b011000, 13);
        stop();

        // Mid-run update to div_m=3: loads at cnt=5, next period is 4.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                div_m   = 4'd3;
                upd_req = 1'b1;
            end
            step(pat(i, 16'b000011, 16'b011000), i == 0, i == 5);
        end
        upd_req = 1'b0;
        run(4, 16'b0011, C_P4_CH1, 8);
        stop();

        // Hold-length and offset boundaries.
        cfg(1'b0, 4'd5, 4'd0, 4'd3, 4'd0);
        run(6, 16'h0, 16'h0, 7);
        stop();
        cfg(1'b0, 4'd5, 4'd15, 4'd3, 4'd0);
        run(6, 16'h3f, NOVL ? 16'h0 : 16'h3f, 7);
        stop();
        cfg(1'b0, 4'd5, 4'd15, 4'd9, 4'd0);
        run(6, 16'h3f, 16'h0, 7);
        stop();

        // div_m=0 clamps to P=2; div_m=15 gives P=16.
        cfg(1'b0, 4'd0, 4'd1, 4'd1, 4'd0);
        run(2, 16'b01, 16'b10, 5);
        stop();
        cfg(1'b0, 4'd15, 4'd1, 4'd15, 4'd0);
        run(16, 16'h0001, 16'h8000, 18);
        stop();

        // Half-rate mode: hold and offsets saturate to one bit.
        cfg(1'b1, 4'd9, 4'd5, 4'd3, 4'd0);
        run(2, 16'b01, 16'b10, 6);
        stop();

        // Overlapping windows.
        cfg(1'b0, 4'd5, 4'd4, 4'd2, 4'd0);
        run(6, 16'b001111, NOVL ? 16'b110000 : 16'b111100, 7);
        stop();

        // Held request while idle reloads every other cycle.
        mode = 1'b0; div_m = 4'd3; hld_len = 4'd2; ch_ofs = {4'd3, 4'd0};
        upd_req = 1'b1;
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        upd_req = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        run(4, 16'b0011, C_P4_CH1, 4);
        stop();

        // Reset at cnt=4 during a request aborts the load.
        cfg(1'b0, 4'd5, 4'd2, 4'd3, 4'd0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(pat(i, 16'b000011, 16'b011000), i == 0, 1'b0);
        end
        div_m = 4'd3; upd_req = 1'b1; rst = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        rst = 1'b0; upd_req = 1'b0;
        run(2, 16'h0, 16'h0, 4);
        stop();

        // Request held through reset is serviced after release with en low.
        rst = 1'b1; upd_req = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        step(2'b00, 1'b0, 1'b1);
        upd_req = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        run(4, 16'b0011, C_P4_CH1, 8);
        stop();

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
